// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage RV32I pipeline.
//
// Issues data-cache requests for the instruction held in the EX/MEM slot.
// Freezes the front of the pipeline while an access is outstanding.
// Formats load data and registers the MEM/WB slot used by writeback and forwarding.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   ex_*              EX/MEM slot contents (valid, load/store, funct3, MAR, rs2, ALU result, rd)
//   pipe_hold         external freeze; MEM/WB holds and a completed access parks in DONE
//   dmem_resp/rdata   data-cache completion pulse and read word
//   dmem_*            data-cache request: read/write strobes, word address, byte mask, lane data
//   mem_stall         request outstanding without a response this cycle
//   wb_*              MEM/WB slot: valid, rd, write-enable, data, misaligned flag
//   load/store_count  completed load and store accesses (wrapping)
module mem_stage #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic             ex_is_store,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_addr,
    input  logic [31:0]      ex_store_data,
    input  logic [31:0]      ex_alu_out,
    input  logic [4:0]       ex_rd,
    input  logic             ex_load_regfile,
    input  logic             pipe_hold,
    input  logic             dmem_resp,
    input  logic [31:0]      dmem_rdata,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [31:0]      dmem_address,
    output logic [3:0]       dmem_wmask,
    output logic [31:0]      dmem_wdata,
    output logic             mem_stall,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic             wb_load_regfile,
    output logic [31:0]      wb_rd_data,
    output logic             wb_misaligned,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [31:0] done_data_q;

    logic             wb_valid_q, wb_load_regfile_q, wb_misaligned_q;
    logic [4:0]       wb_rd_q;
    logic [31:0]      wb_rd_data_q;
    logic [CNT_W-1:0] load_count_q, store_count_q;

    logic        op, mis, req, complete;
    logic [1:0]  lane;
    logic [31:0] rshift, fmt, wb_data_d;
    logic [3:0]  mask_raw;

    // Access decode and misalignment.
    always_comb begin
        op   = ex_valid & (ex_is_load | ex_is_store);
        lane = ex_addr[1:0];
        mis  = 1'b0;
        if (op) begin
            case (ex_funct3[1:0])
                2'b01:   mis = ex_addr[0];
                2'b10:   mis = |ex_addr[1:0];
                default: mis = 1'b0;
            endcase
        end
        // DONE already has its data; never re-request from there.
        req      = op & ~mis & ~rst & (state_q != StDone);
        complete = req & dmem_resp;
    end

    // Load formatting: move the addressed lane down to bit 0, then extend.
    always_comb begin
        rshift = dmem_rdata >> {lane, 3'b000};
        fmt    = '0;
        case (ex_funct3)
            3'b000:  fmt = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  fmt = {{16{rshift[15]}}, rshift[15:0]};
            3'b010:  fmt = dmem_rdata;
            3'b100:  fmt = {24'h0, rshift[7:0]};
            3'b101:  fmt = {16'h0, rshift[15:0]};
            default: fmt = '0;
        endcase
    end

    // Store lane steering.
    always_comb begin
        mask_raw = '0;
        case (ex_funct3[1:0])
            2'b00:   mask_raw = 4'b0001 << lane;
            2'b01:   mask_raw = 4'b0011 << lane;
            2'b10:   mask_raw = 4'b1111;
            default: mask_raw = '0;
        endcase
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    if (dmem_resp) state_d = pipe_hold ? StDone : StIdle;
                    else           state_d = StWait;
                end
            end
            StWait: begin
                if (!req) begin
                    state_d = StIdle;
                end else if (dmem_resp) begin
                    state_d = pipe_hold ? StDone : StIdle;
                end
            end
            StDone: begin
                if (!pipe_hold) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Once parked in DONE the cache word is gone; use the copy taken in the response cycle.
    always_comb begin
        if (ex_is_load) begin
            wb_data_d = (state_q == StDone) ? done_data_q : fmt;
        end else begin
            wb_data_d = ex_alu_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= StIdle;
            done_data_q       <= '0;
            wb_valid_q        <= 1'b0;
            wb_rd_q           <= '0;
            wb_load_regfile_q <= 1'b0;
            wb_rd_data_q      <= '0;
            wb_misaligned_q   <= 1'b0;
            load_count_q      <= '0;
            store_count_q     <= '0;
        end else begin
            state_q <= state_d;
            if (complete) begin
                done_data_q <= fmt;
                if (ex_is_load)       load_count_q  <= load_count_q + 1'b1;
                else if (ex_is_store) store_count_q <= store_count_q + 1'b1;
            end
            if (!pipe_hold) begin
                if (mem_stall) begin
                    wb_valid_q <= 1'b0;
                end else begin
                    wb_valid_q        <= ex_valid;
                    wb_rd_q           <= ex_rd;
                    wb_load_regfile_q <= ex_load_regfile & ~mis;
                    wb_rd_data_q      <= wb_data_d;
                    wb_misaligned_q   <= mis;
                end
            end
        end
    end

    assign dmem_read       = req & ex_is_load;
    assign dmem_write      = req & ex_is_store & ~ex_is_load;
    assign dmem_address    = {ex_addr[31:2], 2'b00};
    assign dmem_wmask      = dmem_write ? mask_raw : 4'b0000;
    assign dmem_wdata      = ex_store_data << {lane, 3'b000};
    assign mem_stall       = req & ~dmem_resp;
    assign wb_valid        = wb_valid_q;
    assign wb_rd           = wb_rd_q;
    assign wb_load_regfile = wb_load_regfile_q;
    assign wb_rd_data      = wb_rd_data_q;
    assign wb_misaligned   = wb_misaligned_q;
    assign load_count      = load_count_q;
    assign store_count     = store_count_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table plus hand-written multi-cycle sequences for mem_stage.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_load, ex_is_store, ex_load_regfile;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_store_data, ex_alu_out;
    logic [4:0]  ex_rd;
    logic        pipe_hold, dmem_resp;
    logic [31:0] dmem_rdata;
    logic        dmem_read, dmem_write, mem_stall;
    logic [31:0] dmem_address, dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        wb_valid, wb_load_regfile, wb_misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_rd_data;
    logic [31:0] load_count, store_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ld  = 0;
    int exp_st  = 0;

    mem_stage #(.CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid        (ex_valid),
        .ex_is_load      (ex_is_load),
        .ex_is_store     (ex_is_store),
        .ex_funct3       (ex_funct3),
        .ex_addr         (ex_addr),
        .ex_store_data   (ex_store_data),
        .ex_alu_out      (ex_alu_out),
        .ex_rd           (ex_rd),
        .ex_load_regfile (ex_load_regfile),
        .pipe_hold       (pipe_hold),
        .dmem_resp       (dmem_resp),
        .dmem_rdata      (dmem_rdata),
        .dmem_read       (dmem_read),
        .dmem_write      (dmem_write),
        .dmem_address    (dmem_address),
        .dmem_wmask      (dmem_wmask),
        .dmem_wdata      (dmem_wdata),
        .mem_stall       (mem_stall),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_load_regfile (wb_load_regfile),
        .wb_rd_data      (wb_rd_data),
        .wb_misaligned   (wb_misaligned),
        .load_count      (load_count),
        .store_count     (store_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        lr;
        logic        e_rd;
        logic        e_wr;
        logic [3:0]  e_mask;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_wb;
        logic        e_mis;
        logic        e_lr;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] alu, input logic [31:0] rdata, input logic lr,
                                input logic e_rd, input logic e_wr, input logic [3:0] e_mask,
                                input logic [31:0] e_addr, input logic [31:0] e_wdata,
                                input logic [31:0] e_wb, input logic e_mis, input logic e_lr);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.alu = alu;
        v.rdata = rdata; v.lr = lr; v.e_rd = e_rd; v.e_wr = e_wr; v.e_mask = e_mask;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wb = e_wb; v.e_mis = e_mis; v.e_lr = e_lr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] alu, input logic [4:0] rd, input logic lr);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3; ex_addr = addr;
        ex_store_data = sdata; ex_alu_out = alu; ex_rd = rd; ex_load_regfile = lr;
    endtask

    initial begin
        int stalls;

        //           ld st f3    addr          sdata         alu           rdata         lr
        //           rd wr mask  addr          wdata         wb            mis lr
        vecs[0]  = mk(1, 0, 3'd0, 32'h103, 32'h0, 32'h0, 32'h80FF_0000, 1,
                      1, 0, 4'h0, 32'h100, 32'h0, 32'hFFFF_FF80, 0, 1);      // LB
        vecs[1]  = mk(1, 0, 3'd4, 32'h103, 32'h0, 32'h0, 32'h80FF_0000, 1,
                      1, 0, 4'h0, 32'h100, 32'h0, 32'h0000_0080, 0, 1);      // LBU
        vecs[2]  = mk(1, 0, 3'd1, 32'h102, 32'h0, 32'h0, 32'h80FF_0000, 1,
                      1, 0, 4'h0, 32'h100, 32'h0, 32'hFFFF_80FF, 0, 1);      // LH
        vecs[3]  = mk(1, 0, 3'd5, 32'h100, 32'h0, 32'h0, 32'h1234_8765, 1,
                      1, 0, 4'h0, 32'h100, 32'h0, 32'h0000_8765, 0, 1);      // LHU
        vecs[4]  = mk(1, 0, 3'd2, 32'h104, 32'h0, 32'h0, 32'hCAFE_F00D, 1,
                      1, 0, 4'h0, 32'h104, 32'h0, 32'hCAFE_F00D, 0, 1);      // LW
        vecs[5]  = mk(1, 0, 3'd0, 32'h101, 32'h0, 32'h0, 32'h0000_7F00, 1,
                      1, 0, 4'h0, 32'h100, 32'h0, 32'h0000_007F, 0, 1);      // LB +ve
        vecs[6]  = mk(0, 1, 3'd1, 32'h202, 32'h1234_ABCD, 32'h202, 32'h0, 0,
                      0, 1, 4'hC, 32'h200, 32'hABCD_0000, 32'h202, 0, 0);   // SH
        vecs[7]  = mk(0, 1, 3'd0, 32'h301, 32'h0000_00AA, 32'h301, 32'h0, 0,
                      0, 1, 4'h2, 32'h300, 32'h0000_AA00, 32'h301, 0, 0);   // SB
        vecs[8]  = mk(0, 1, 3'd2, 32'h400, 32'h1122_3344, 32'h400, 32'h0, 0,
                      0, 1, 4'hF, 32'h400, 32'h1122_3344, 32'h400, 0, 0);   // SW
        vecs[9]  = mk(1, 0, 3'd2, 32'h101, 32'h0, 32'h0, 32'h0, 1,
                      0, 0, 4'h0, 32'h100, 32'h0, 32'h0, 1, 0);             // LW misaligned
        vecs[10] = mk(1, 0, 3'd1, 32'h103, 32'h0, 32'h0, 32'h0, 1,
                      0, 0, 4'h0, 32'h100, 32'h0, 32'h0, 1, 0);             // LH misaligned
        vecs[11] = mk(0, 1, 3'd2, 32'h402, 32'h0000_BEEF, 32'h402, 32'h0, 0,
                      0, 0, 4'h0, 32'h400, 32'hBEEF_0000, 32'h402, 1, 0);   // SW misaligned
        vecs[12] = mk(0, 0, 3'd1, 32'h001, 32'h0, 32'h1234_5678, 32'h0, 1,
                      0, 0, 4'h0, 32'h0, 32'h0, 32'h1234_5678, 0, 1);       // ALU op

        rst = 1'b1; pipe_hold = 1'b0; dmem_resp = 1'b0; dmem_rdata = '0;
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        ex_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("reset wb_rd_data", wb_rd_data, 32'h0);
        chk("reset load_count", load_count, 32'h0);
        chk("reset store_count", store_count, 32'h0);

        // Table: combinational request checks, then a zero-wait response, then MEM/WB checks.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].sdata, vecs[i].alu,
                  5'(i + 1), vecs[i].lr);
            dmem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d dmem_read", i), {31'h0, dmem_read}, {31'h0, vecs[i].e_rd});
            chk($sformatf("v%0d dmem_write", i), {31'h0, dmem_write}, {31'h0, vecs[i].e_wr});
            chk($sformatf("v%0d dmem_wmask", i), {28'h0, dmem_wmask}, {28'h0, vecs[i].e_mask});
            chk($sformatf("v%0d dmem_wdata", i), dmem_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d dmem_address", i), dmem_address, vecs[i].e_addr);
            chk($sformatf("v%0d mem_stall", i), {31'h0, mem_stall},
                {31'h0, vecs[i].e_rd | vecs[i].e_wr});
            if (vecs[i].e_rd || vecs[i].e_wr) begin
                dmem_resp = 1'b1;
                #1;
                chk($sformatf("v%0d stall on resp", i), {31'h0, mem_stall}, 32'h0);
                if (vecs[i].e_rd) exp_ld++;
                else exp_st++;
            end
            tick();
            dmem_resp = 1'b0;
            chk($sformatf("v%0d wb_valid", i), {31'h0, wb_valid}, 32'h1);
            chk($sformatf("v%0d wb_rd", i), {27'h0, wb_rd}, i + 1);
            chk($sformatf("v%0d wb_rd_data", i), wb_rd_data, vecs[i].e_wb);
            chk($sformatf("v%0d wb_misaligned", i), {31'h0, wb_misaligned},
                {31'h0, vecs[i].e_mis});
            chk($sformatf("v%0d wb_load_regfile", i), {31'h0, wb_load_regfile},
                {31'h0, vecs[i].e_lr});
        end
        chk("table load_count", load_count, exp_ld);
        chk("table store_count", store_count, exp_st);

        // LW with a 3-cycle wait.
        drive(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'h0, 5'd7, 1'b1);
        dmem_rdata = 32'hDEAD_BEEF;
        stalls = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (mem_stall) stalls++;
            tick();
        end
        chk("wait bubble wb_valid", {31'h0, wb_valid}, 32'h0);
        dmem_resp = 1'b1;
        #1;
        chk("wait resp stall", {31'h0, mem_stall}, 32'h0);
        tick();
        dmem_resp = 1'b0; ex_valid = 1'b0;
        exp_ld++;
        chk("wait stall cycles", stalls, 3);
        chk("wait wb_rd_data", wb_rd_data, 32'hDEAD_BEEF);
        chk("wait wb_valid", {31'h0, wb_valid}, 32'h1);
        chk("wait load_count", load_count, exp_ld);
        tick();

        // Response under pipe_hold: park in DONE, replay latched data on release.
        drive(1'b1, 1'b0, 3'd2, 32'h010, 32'h0, 32'h0, 5'd9, 1'b1);
        tick();
        pipe_hold = 1'b1; dmem_resp = 1'b1; dmem_rdata = 32'h0000_0055;
        #1;
        chk("hold resp stall", {31'h0, mem_stall}, 32'h0);
        tick();
        dmem_resp = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
        exp_ld++;
        #1;
        chk("done no re-request", {31'h0, dmem_read}, 32'h0);
        chk("done no stall", {31'h0, mem_stall}, 32'h0);
        chk("done wb held", {31'h0, wb_valid}, 32'h0);
        tick();
        pipe_hold = 1'b0;
        #1;
        chk("release no re-request", {31'h0, dmem_read}, 32'h0);
        tick();
        ex_valid = 1'b0;
        chk("release wb_rd_data", wb_rd_data, 32'h0000_0055);
        chk("release wb_valid", {31'h0, wb_valid}, 32'h1);
        chk("release wb_rd", {27'h0, wb_rd}, 32'd9);
        chk("release load_count", load_count, exp_ld);
        tick();
        chk("retired once wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("retired once load_count", load_count, exp_ld);

        // Reset while a store is waiting; the stray response must be dropped.
        drive(1'b0, 1'b1, 3'd2, 32'h500, 32'hA5A5_A5A5, 32'h500, 5'd3, 1'b0);
        tick();
        rst = 1'b1; dmem_resp = 1'b1;
        #1;
        chk("rst dmem_write", {31'h0, dmem_write}, 32'h0);
        chk("rst mem_stall", {31'h0, mem_stall}, 32'h0);
        tick();
        rst = 1'b0; dmem_resp = 1'b0;
        drive(1'b1, 1'b0, 3'd2, 32'h600, 32'h0, 32'h0, 5'd4, 1'b1);
        #1;
        chk("post-rst wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("post-rst load_count", load_count, 32'h0);
        chk("post-rst store_count", store_count, 32'h0);
        chk("post-rst new request", {31'h0, dmem_read}, 32'h1);
        chk("post-rst stall", {31'h0, mem_stall}, 32'h1);
        dmem_resp = 1'b1; dmem_rdata = 32'h0BAD_F00D;
        tick();
        dmem_resp = 1'b0; ex_valid = 1'b0;
        chk("post-rst wb_rd_data", wb_rd_data, 32'h0BAD_F00D);
        chk("post-rst load_count 1", load_count, 32'h1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
